sifive_scope_trace_capture: RTL and testbench

Downstream consumer of the hart-0 core-monitor trace bundle: samples every retirement/exception/interrupt record from the hart's commit stage, buffers it in a small FIFO, and presents it on a valid/ready stream toward the scope encoder/packetizer. Records the hart emits while the FIFO is full are dropped. Drops are counted, and the next record that is accepted is flagged. The block never backpressures the hart.

---
 rtl/sifive_scope_trace_capture.sv | 166 ++++++++++++++++
 tb/tb_sifive_scope_trace_capture.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sifive_scope_trace_capture.sv
// sifive_scope_trace_capture
//
// Captures hart-0 core-monitor trace records (retire / exception / interrupt)
// into a small circular FIFO and presents them on a valid/ready stream toward
// the scope encoder. The hart is never backpressured: records that arrive
// while the FIFO is full are dropped, counted in a saturating counter, and the
// next accepted record is tagged with out_gap.
//
// Ports:
//   clock, reset_n                  clock, asynchronous active-low reset
//   enable                          capture enable (draining continues when low)
//   commit, exception,
//   interrupt_fire                  trace event strobes
//   pc, instruction, mode           commit-stage address / instruction / {debug, priv}
//   rd_wenx, rd_wenf, rd_waddr,
//   rd_wdata                        register write-back info
//   out_valid / out_ready           output stream handshake
//   out_*                           head-of-FIFO record fields
//   out_gap                         one or more records were dropped just before this one
//   fifo_level                      current occupancy (0..DEPTH)
//   drop_count, drop_clear          saturating drop counter and its synchronous clear
module sifive_scope_trace_capture #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     commit,
    input  logic                     exception,
    input  logic                     interrupt_fire,
    input  logic [31:0]              pc,
    input  logic [31:0]              instruction,
    input  logic [2:0]               mode,
    input  logic                     rd_wenx,
    input  logic                     rd_wenf,
    input  logic [4:0]               rd_waddr,
    input  logic [31:0]              rd_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instruction,
    output logic [2:0]               out_mode,
    output logic                     out_exception,
    output logic                     out_interrupt,
    output logic                     out_wenx,
    output logic                     out_wenf,
    output logic [4:0]               out_waddr,
    output logic [31:0]              out_wdata,
    output logic                     out_gap,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNTW-1:0]          drop_count,
    input  logic                     drop_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [2:0]  mode;
        logic        exception;
        logic        interrupt;
        logic        wenx;
        logic        wenf;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        gap;
    } record_t;

    record_t     mem [DEPTH];
    record_t     new_rec;
    record_t     head;
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] level;
    logic        gap_pending;
    logic        trace_event;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;

    // Pointers carry one extra wrap bit, so their difference is the occupancy
    // with full (DEPTH) and empty (0) kept distinct.
    assign level       = wptr - rptr;
    assign full        = (level == FULL_LEVEL);
    assign out_valid   = (level != '0);
    assign fifo_level  = level;

    assign trace_event = enable & (commit | exception | interrupt_fire);
    assign pop         = out_valid & out_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push        = trace_event & (~full | pop);
    assign drop        = trace_event & full & ~pop;

    always_comb begin
        // NOTE: every field gets a value on every path, so no latch is inferred.
        new_rec             = '0;
        new_rec.pc          = pc;
        new_rec.instruction = instruction;
        new_rec.mode        = mode;
        new_rec.exception   = exception;
        new_rec.interrupt   = interrupt_fire;
        // Only a retiring instruction writes a register.
        new_rec.wenx        = rd_wenx & commit;
        new_rec.wenf        = rd_wenf & commit;
        new_rec.waddr       = rd_waddr;
        new_rec.wdata       = rd_wdata;
        new_rec.gap         = gap_pending;
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which
    // entries are live, and out_* are don't-care while out_valid is low.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= new_rec;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            gap_pending <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + (AW + 1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW + 1)'(1);
            end

            if (push) begin
                gap_pending <= 1'b0;
            end else if (drop) begin
                gap_pending <= 1'b1;
            end

            // A clear coinciding with a drop leaves that drop counted.
            if (drop_clear) begin
                drop_count <= drop ? CNTW'(1) : '0;
            end else if (drop && (drop_count != CNT_MAX)) begin
                drop_count <= drop_count + CNTW'(1);
            end
        end
    end

    assign head            = mem[rptr[AW-1:0]];
    assign out_pc          = head.pc;
    assign out_instruction = head.instruction;
    assign out_mode        = head.mode;
    assign out_exception   = head.exception;
    assign out_interrupt   = head.interrupt;
    assign out_wenx        = head.wenx;
    assign out_wenf        = head.wenf;
    assign out_waddr       = head.waddr;
    assign out_wdata       = head.wdata;
    assign out_gap         = head.gap;

endmodule

// File: tb/tb_sifive_scope_trace_capture.sv
// tb_sifive_scope_trace_capture
//
// Directed bench for sifive_scope_trace_capture. Two instances share all
// inputs: the default one (CNTW=16) and a narrow-counter one (CNTW=4) used to
// observe drop-counter saturation. A queue-based reference model tracks the
// expected FIFO contents, drop counts and gap flag; a compare process checks
// both instances against it on every falling edge, and literal expectations
// at key points pin the model itself.
module tb_sifive_scope_trace_capture;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        commit;
    logic        exception;
    logic        interrupt_fire;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [2:0]  mode;
    logic        rd_wenx;
    logic        rd_wenf;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        out_ready;
    logic        drop_clear;

    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [2:0]  out_mode;
    logic        out_exception;
    logic        out_interrupt;
    logic        out_wenx;
    logic        out_wenf;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;
    logic        out_gap;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;

    logic        n_valid;
    logic [31:0] n_pc;
    logic [31:0] n_instruction;
    logic [2:0]  n_mode;
    logic        n_exception;
    logic        n_interrupt;
    logic        n_wenx;
    logic        n_wenf;
    logic [4:0]  n_waddr;
    logic [31:0] n_wdata;
    logic        n_gap;
    logic [3:0]  n_level;
    logic [3:0]  n_drop_count;

    sifive_scope_trace_capture #(.DEPTH(DEPTH), .CNTW(16)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .commit(commit), .exception(exception), .interrupt_fire(interrupt_fire),
        .pc(pc), .instruction(instruction), .mode(mode),
        .rd_wenx(rd_wenx), .rd_wenf(rd_wenf), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instruction(out_instruction), .out_mode(out_mode),
        .out_exception(out_exception), .out_interrupt(out_interrupt),
        .out_wenx(out_wenx), .out_wenf(out_wenf), .out_waddr(out_waddr),
        .out_wdata(out_wdata), .out_gap(out_gap),
        .fifo_level(fifo_level), .drop_count(drop_count), .drop_clear(drop_clear)
    );

    sifive_scope_trace_capture #(.DEPTH(DEPTH), .CNTW(4)) dut_narrow (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .commit(commit), .exception(exception), .interrupt_fire(interrupt_fire),
        .pc(pc), .instruction(instruction), .mode(mode),
        .rd_wenx(rd_wenx), .rd_wenf(rd_wenf), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .out_valid(n_valid), .out_ready(out_ready),
        .out_pc(n_pc), .out_instruction(n_instruction), .out_mode(n_mode),
        .out_exception(n_exception), .out_interrupt(n_interrupt),
        .out_wenx(n_wenx), .out_wenf(n_wenf), .out_waddr(n_waddr),
        .out_wdata(n_wdata), .out_gap(n_gap),
        .fifo_level(n_level), .drop_count(n_drop_count), .drop_clear(drop_clear)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [2:0]  mode;
        logic        exc;
        logic        intr;
        logic        wenx;
        logic        wenf;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        gap;
    } rec_t;

    rec_t q[$];
    int   m_drops16;
    int   m_drops4;
    bit   m_gap;
    bit   chk_en;

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    task automatic model_reset();
        q.delete();
        m_drops16 = 0;
        m_drops4  = 0;
        m_gap     = 0;
    endtask

    // Applies one clock edge's worth of behaviour using the inputs held
    // across that edge.
    task automatic model_step();
        bit   ev;
        bit   do_pop;
        bit   was_full;
        bit   dropped;
        rec_t r;
        ev       = enable && (commit || exception || interrupt_fire);
        do_pop   = (q.size() != 0) && out_ready;
        was_full = (q.size() == DEPTH);
        dropped  = 0;
        if (do_pop) void'(q.pop_front());
        if (ev) begin
            if (!was_full || do_pop) begin
                r.pc          = pc;
                r.instruction = instruction;
                r.mode        = mode;
                r.exc         = exception;
                r.intr        = interrupt_fire;
                r.wenx        = rd_wenx && commit;
                r.wenf        = rd_wenf && commit;
                r.waddr       = rd_waddr;
                r.wdata       = rd_wdata;
                r.gap         = m_gap;
                q.push_back(r);
                m_gap = 0;
            end else begin
                dropped = 1;
                m_gap   = 1;
            end
        end
        if (drop_clear) begin
            m_drops16 = dropped ? 1 : 0;
            m_drops4  = dropped ? 1 : 0;
        end else if (dropped) begin
            m_drops16 = sat_inc(m_drops16, 65535);
            m_drops4  = sat_inc(m_drops4, 15);
        end
    endtask

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("valid",  64'(out_valid),    64'(q.size() != 0));
            check("level",  64'(fifo_level),   64'(q.size()));
            check("drops",  64'(drop_count),   64'(m_drops16));
            check("valid4", 64'(n_valid),      64'(q.size() != 0));
            check("level4", 64'(n_level),      64'(q.size()));
            check("drops4", 64'(n_drop_count), 64'(m_drops4));
            if (q.size() != 0) begin
                check("pc",    64'(out_pc),          64'(q[0].pc));
                check("insn",  64'(out_instruction), 64'(q[0].instruction));
                check("wdata", 64'(out_wdata),       64'(q[0].wdata));
                check("misc",
                      64'({out_mode, out_exception, out_interrupt, out_wenx, out_wenf, out_waddr, out_gap}),
                      64'({q[0].mode, q[0].exc, q[0].intr, q[0].wenx, q[0].wenf, q[0].waddr, q[0].gap}));
                check("pc4",   64'(n_pc),            64'(q[0].pc));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clock);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic idle();
        commit         = 0;
        exception      = 0;
        interrupt_fire = 0;
        rd_wenx        = 0;
        rd_wenf        = 0;
        drop_clear     = 0;
    endtask

    task automatic drive_commit(input logic [31:0] p);
        commit         = 1;
        exception      = 0;
        interrupt_fire = 0;
        pc             = p;
        instruction    = 32'h0000_0013 ^ p;
        mode           = 3'b011;
        rd_wenx        = 1;
        rd_wenf        = 0;
        rd_waddr       = p[4:0];
        rd_wdata       = ~p;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 0;
        model_reset();
        reset_n     = 0;
        enable      = 0;
        out_ready   = 0;
        pc          = '0;
        instruction = '0;
        mode        = '0;
        rd_waddr    = '0;
        rd_wdata    = '0;
        idle();

        repeat (2) cycle();
        reset_n = 1;
        chk_en  = 1;
        check("rst_valid", 64'(out_valid),  64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_drops", 64'(drop_count), 64'(0));

        // Single commit, drained immediately.
        enable      = 1;
        out_ready   = 1;
        commit      = 1;
        pc          = 32'h8000_0000;
        instruction = 32'h00a0_0093;
        mode        = 3'b011;
        rd_wenx     = 1;
        rd_waddr    = 5'd1;
        rd_wdata    = 32'd10;
        cycle();
        idle();
        check("single_valid", 64'(out_valid),       64'(1));
        check("single_pc",    64'(out_pc),          64'(32'h8000_0000));
        check("single_insn",  64'(out_instruction), 64'(32'h00a0_0093));
        check("single_wr",    64'({out_wenx, out_waddr, out_wdata}), 64'({1'b1, 5'd1, 32'd10}));
        check("single_gap",   64'(out_gap),         64'(0));
        cycle();
        check("single_gone",  64'(out_valid),       64'(0));
        check("single_lvl0",  64'(fifo_level),      64'(0));

        // Exception without retire: write enables forced low.
        exception = 1;
        rd_wenx   = 1;
        rd_wenf   = 1;
        pc        = 32'h8000_0100;
        cycle();
        check("exc_flag", 64'(out_exception), 64'(1));
        check("exc_wenx", 64'(out_wenx),      64'(0));
        check("exc_wenf", 64'(out_wenf),      64'(0));
        // Interrupt in debug mode, then an idle cycle to drain.
        exception      = 0;
        interrupt_fire = 1;
        mode           = 3'b100;
        pc             = 32'h8000_0200;
        cycle();
        idle();
        cycle();

        // Capture disabled: strobes are ignored.
        enable = 0;
        drive_commit(32'd600);
        cycle();
        idle();
        check("dis_level", 64'(fifo_level), 64'(0));
        enable = 1;

        // Overflow: 11 commits into a stalled FIFO.
        out_ready = 0;
        for (int i = 0; i < 11; i++) begin
            drive_commit(32'(i));
            cycle();
        end
        idle();
        check("ovf_level", 64'(fifo_level), 64'(8));
        check("ovf_drops", 64'(drop_count), 64'(3));
        // Resume draining while pushing pc=100 into the full FIFO.
        out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) drive_commit(32'd100);
            check("ovf_order", 64'(out_pc), 64'(k));
            cycle();
            idle();
        end
        check("ovf_last_pc",  64'(out_pc),  64'(100));
        check("ovf_last_gap", 64'(out_gap), 64'(1));
        cycle();

        // Full FIFO with simultaneous push and pop across pointer wrap.
        out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            drive_commit(32'(200 + i));
            cycle();
        end
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            drive_commit(32'(300 + i));
            cycle();
        end
        idle();
        check("pp_level", 64'(fifo_level), 64'(8));
        check("pp_drops", 64'(drop_count), 64'(3));
        check("pp_head",  64'(out_pc),     64'(312));
        repeat (8) cycle();

        // drop_clear coincident with a drop, then saturation of the narrow counter.
        out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            drive_commit(32'(400 + i));
            cycle();
        end
        drive_commit(32'd408);
        drop_clear = 1;
        cycle();
        drop_clear = 0;
        check("clr_drops",  64'(drop_count),   64'(1));
        check("clr_drops4", 64'(n_drop_count), 64'(1));
        for (int i = 0; i < 20; i++) begin
            drive_commit(32'(420 + i));
            cycle();
        end
        idle();
        check("sat_drops16", 64'(drop_count),   64'(21));
        check("sat_drops4",  64'(n_drop_count), 64'(15));
        out_ready = 1;
        repeat (8) cycle();

        // Asynchronous reset with five records held.
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            drive_commit(32'(450 + i));
            cycle();
        end
        idle();
        check("pre_rst_level", 64'(fifo_level), 64'(5));
        #2;
        reset_n = 0;
        model_reset();
        #1;
        check("arst_valid", 64'(out_valid),  64'(0));
        check("arst_level", 64'(fifo_level), 64'(0));
        check("arst_drops", 64'(drop_count), 64'(0));
        cycle();
        reset_n   = 1;
        out_ready = 1;
        drive_commit(32'd500);
        cycle();
        idle();
        check("post_rst_valid", 64'(out_valid), 64'(1));
        check("post_rst_pc",    64'(out_pc),    64'(500));
        check("post_rst_gap",   64'(out_gap),   64'(0));
        repeat (2) cycle();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
